// File: rtl/score_counter.sv
// score_counter: button/command front end for the 3-digit score display.
// Two raw buttons go through synchronisers, tick-sampled debouncers and
// one-pulse detectors. Game-logic commands (clr, add_en) and the button
// pulses update a saturating 8-bit score.
// The rst_n port is an active-high synchronous reset.
// Optional build macro SCORE_AUTOREPEAT_EN adds auto-repeat on held buttons.
// DEB_LEN must be at least 2.
module score_counter #(
  parameter int MAX_SCORE = 255,
  parameter int DIV_BITS  = 16,
  parameter int DEB_LEN   = 4
`ifdef SCORE_AUTOREPEAT_EN
  ,
  parameter int REP_DELAY = 16,
  parameter int REP_RATE  = 4
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       clr,
  input  logic       add_en,
  input  logic [7:0] add_val,
  output logic [7:0] num,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       sat_hit
);

  localparam logic [7:0] MAX8 = 8'(MAX_SCORE);
  localparam logic [8:0] MAX9 = 9'(MAX_SCORE);

  // Clip a 9-bit sum to the score ceiling.
  function automatic logic [7:0] clip_score(input logic [8:0] sum);
    return (sum > MAX9) ? MAX8 : sum[7:0];
  endfunction

  // True when a 9-bit sum had to be clipped.
  function automatic logic over_max(input logic [8:0] sum);
    return (sum > MAX9);
  endfunction

  // Index 0 = increment button, index 1 = decrement button.
  logic [1:0]          btn_raw;
  logic [1:0]          sync_p0, sync_p1;
  logic [DEB_LEN-1:0]  shreg [2];
  logic [1:0]          lvl, lvl_prev, pulse_p;
  logic [1:0]          rep_fire;
  logic [DIV_BITS-1:0] pre_cnt;
  logic                tick;
  logic [8:0]          add_sum;

  assign btn_raw = {btn_dec, btn_inc};
  assign tick    = &pre_cnt;
  assign add_sum = {1'b0, num} + {1'b0, add_val};

  // Free-running prescaler; tick marks the all-ones cycle before wrap.
  always_ff @(posedge clk) begin
    if (rst_n) pre_cnt <= '0;
    else       pre_cnt <= pre_cnt + 1'b1;
  end

  // ---- stage p0/p1: two-flop synchronisers for the asynchronous buttons
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // ---- debounce: sample on tick, level flips only on a full run of equal samples
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int b = 0; b < 2; b++) shreg[b] <= '0;
      lvl <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (tick) shreg[b] <= {shreg[b][DEB_LEN-2:0], sync_p1[b]};
        if (&shreg[b])       lvl[b] <= 1'b1;
        else if (~|shreg[b]) lvl[b] <= 1'b0;
      end
    end
  end

`ifdef SCORE_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REP_DELAY + REP_RATE) + 1;
  logic [REP_W-1:0] rep_cnt [2];
  logic [REP_W-1:0] rep_nxt [2];

  // Next repeat count: counts ticks up to the delay, then cycles through the rate window.
  always_comb begin
    rep_fire = '0;
    for (int b = 0; b < 2; b++) begin
      rep_nxt[b] = (rep_cnt[b] == REP_W'(REP_DELAY + REP_RATE - 1)) ?
                   REP_W'(REP_DELAY) : rep_cnt[b] + 1'b1;
      rep_fire[b] = tick & lvl[b] & (rep_nxt[b] == REP_W'(REP_DELAY));
    end
  end

  // Repeat tick counters run only while the debounced level is held high.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (rst_n || !lvl[b]) rep_cnt[b] <= '0;
      else if (tick)        rep_cnt[b] <= rep_nxt[b];
    end
  end
`else
  assign rep_fire = '0;
`endif

  // ---- one-pulse: registered rising-edge detect of the debounced levels
  always_ff @(posedge clk) begin
    if (rst_n) begin
      lvl_prev <= '0;
      pulse_p  <= '0;
    end else begin
      lvl_prev <= lvl;
      pulse_p  <= (lvl & ~lvl_prev) | rep_fire;
    end
  end

  assign inc_pulse = pulse_p[0];
  assign dec_pulse = pulse_p[1];

  // ---- score: commands outrank button pulses; pulses lost to a command are dropped
  always_ff @(posedge clk) begin
    if (rst_n) begin
      num     <= '0;
      sat_hit <= 1'b0;
    end else if (clr) begin
      num     <= '0;
      sat_hit <= 1'b0;
    end else if (add_en) begin
      num     <= clip_score(add_sum);
      sat_hit <= over_max(add_sum);
    end else if (inc_pulse && !dec_pulse) begin
      if (num == MAX8) begin
        sat_hit <= 1'b1;
      end else begin
        num     <= num + 8'd1;
        sat_hit <= 1'b0;
      end
    end else if (dec_pulse && !inc_pulse) begin
      if (num == 8'd0) begin
        sat_hit <= 1'b1;
      end else begin
        num     <= num - 8'd1;
        sat_hit <= 1'b0;
      end
    end else begin
      sat_hit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_score_counter.sv
// Scoreboard bench for score_counter (DIV_BITS = 2, DEB_LEN = 4, MAX_SCORE = 255).
// Stimulus pushes the expected output events; a negedge monitor pops one
// entry whenever the DUT shows a pulse, a sat_hit or a change of num.
module tb_score_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_inc = 1'b0, btn_dec = 1'b0, clr = 1'b0, add_en = 1'b0;
  logic [7:0] add_val = 8'd0;
  logic [7:0] num;
  logic       inc_pulse, dec_pulse, sat_hit;

  typedef struct packed {
    logic       inc;
    logic       dec;
    logic       sat;
    logic [7:0] val;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_inc_cyc = 0;
  logic mon_en = 1'b0;
  logic [7:0] last_num = 8'd0;

  score_counter #(.MAX_SCORE(255), .DIV_BITS(2), .DEB_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .clr(clr), .add_en(add_en), .add_val(add_val),
    .num(num), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .sat_hit(sat_hit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any visible output activity must match the next expected event.
  always @(negedge clk) begin
    if (mon_en && !rst_n) begin
      if (inc_pulse || dec_pulse || sat_hit || num != last_num) begin
        ev_t act, e;
        act = '{inc: inc_pulse, dec: dec_pulse, sat: sat_hit, val: num};
        if (inc_pulse) last_inc_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got inc=%0b dec=%0b sat=%0b num=%0d, required no event",
                   act.inc, act.dec, act.sat, act.val);
        end else begin
          e = exp_q.pop_front();
          if (act != e) begin
            errors++;
            $display("FAIL event: got inc=%0b dec=%0b sat=%0b num=%0d, required inc=%0b dec=%0b sat=%0b num=%0d",
                     act.inc, act.dec, act.sat, act.val, e.inc, e.dec, e.sat, e.val);
          end
        end
      end
    end
    last_num = num;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic i, input logic d, input logic s, input logic [7:0] v);
    exp_q.push_back('{inc: i, dec: d, sat: s, val: v});
  endtask

  task automatic cmd_add(input logic [7:0] v);
    add_en = 1'b1; add_val = v;
    step();
    add_en = 1'b0; add_val = 8'd0;
  endtask

  task automatic cmd_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic press(input logic i, input logic d, input int hold);
    btn_inc = i; btn_dec = d;
    repeat (hold) step();
    btn_inc = 1'b0; btn_dec = 1'b0;
  endtask

  // Wait (bounded) for the scoreboard to empty, then idle so any stray event shows up.
  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d events still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (32) step();
  endtask

  task automatic check_num(input string name, input logic [7:0] want);
    checks++;
    if (num !== want) begin
      errors++;
      $display("FAIL %s: num=%0d, required %0d", name, num, want);
    end
  endtask

  initial begin
    int t0, lat;
    // Reset held for 5 cycles with inputs toggling.
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      btn_inc = k[0]; btn_dec = ~k[0]; clr = k[1]; add_en = ~k[1]; add_val = 8'd9;
      @(negedge clk);
      checks++;
      if ({num, inc_pulse, dec_pulse, sat_hit} !== 11'd0) begin
        errors++;
        $display("FAIL reset_hold: num=%0d inc=%0b dec=%0b sat=%0b, required all 0",
                 num, inc_pulse, dec_pulse, sat_hit);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    btn_inc = 1'b0; btn_dec = 1'b0; clr = 1'b0; add_en = 1'b0; add_val = 8'd0;
    @(negedge clk);
    checks++;
    if ({num, inc_pulse, dec_pulse, sat_hit} !== 11'd0) begin
      errors++;
      $display("FAIL reset_release: num=%0d inc=%0b dec=%0b sat=%0b, required all 0",
               num, inc_pulse, dec_pulse, sat_hit);
    end
    mon_en = 1'b1;
    step();

    // Steady press: one pulse, num 0 -> 1, nothing more while held.
    expect_ev(1, 0, 0, 8'd0);
    expect_ev(0, 0, 0, 8'd1);
    t0 = cyc;
    press(1, 0, 40);
    drain("steady_press", 60);
    lat = last_inc_cyc - t0;
    checks++;
    if (lat < 16 || lat > 21) begin
      errors++;
      $display("FAIL press_latency: %0d cycles, required 16..21", lat);
    end

    // Bouncing input that flips every tick never settles.
    btn_inc = 1'b1;
    for (int k = 0; k < 25; k++) begin
      repeat (4) step();
      btn_inc = ~btn_inc;
    end
    btn_inc = 1'b0;
    repeat (32) step();
    check_num("bounce_no_change", 8'd1);

    // Adding zero changes nothing.
    cmd_add(8'd0);
    step();
    check_num("add_zero", 8'd1);

    // Saturating add, then increment at the ceiling.
    expect_ev(0, 0, 0, 8'd250);
    cmd_add(8'd249);
    expect_ev(0, 0, 1, 8'd255);
    cmd_add(8'd10);
    expect_ev(1, 0, 0, 8'd255);
    expect_ev(0, 0, 1, 8'd255);
    press(1, 0, 30);
    drain("inc_at_max", 60);

    // Landing exactly on the ceiling is not a clip.
    expect_ev(0, 0, 0, 8'd0);
    cmd_clr();
    expect_ev(0, 0, 0, 8'd250);
    cmd_add(8'd250);
    expect_ev(0, 0, 0, 8'd255);
    cmd_add(8'd5);
    drain("add_exact_max", 10);

    // clr beats add_en; then decrement at the floor.
    expect_ev(0, 0, 0, 8'd0);
    cmd_clr();
    expect_ev(0, 0, 0, 8'd3);
    cmd_add(8'd3);
    expect_ev(0, 0, 0, 8'd0);
    clr = 1'b1; add_en = 1'b1; add_val = 8'd7;
    step();
    clr = 1'b0; add_en = 1'b0; add_val = 8'd0;
    expect_ev(0, 1, 0, 8'd0);
    expect_ev(0, 0, 1, 8'd0);
    press(0, 1, 30);
    drain("dec_at_zero", 60);

    // Both buttons together cancel; then a normal decrement and increment.
    expect_ev(0, 0, 0, 8'd5);
    cmd_add(8'd5);
    expect_ev(1, 1, 0, 8'd5);
    press(1, 1, 30);
    drain("both_buttons", 60);
    expect_ev(0, 1, 0, 8'd5);
    expect_ev(0, 0, 0, 8'd4);
    press(0, 1, 30);
    drain("dec_normal", 60);
    expect_ev(1, 0, 0, 8'd4);
    expect_ev(0, 0, 0, 8'd5);
    press(1, 0, 30);
    drain("inc_normal", 60);
    check_num("final_num", 8'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
